// File: rtl/non_ssc_pkg.sv
// Shared types and constants for the non_ssc_detector slice.
// Also holds the prefix-matching helpers that build the FSM transition
// table at elaboration time.
// The optional macro NON_SSC_OVERLAP_EN is consumed in non_ssc_detector.sv.
package non_ssc_pkg;

    // The FSM state is the number of pattern bits matched so far.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam int         DEF_SAMPLE_DIV = 500;
    localparam logic [3:0] DEF_PATTERN    = 4'b1011;

    // Bit positions inside out_light.
    localparam int DETECT_BIT = 4;
    localparam int HIST_LSB   = 0;

    // Inputs: k pattern bits already matched, then bit b arrives.
    // Returns the longest prefix of pat (at most k+1 bits) that is a
    // suffix of that k+1 bit sequence.
    // A result of 4 means the whole pattern has matched.
    function automatic int match_len(input int k, input int b, input logic [3:0] pat);
        int p;
        int seq;
        int res;
        p   = int'(pat);
        res = 0;
        seq = ((p >> (4 - k)) << 1) | (b & 1);
        for (int len = 1; len <= 4; len++) begin
            if (len <= k + 1 && (seq & ((1 << len) - 1)) == (p >> (4 - len)))
                res = len;
        end
        return res;
    endfunction

    // Longest proper prefix of pat that is also a suffix of pat.
    function automatic int border_len(input logic [3:0] pat);
        int p;
        int res;
        p   = int'(pat);
        res = 0;
        for (int len = 1; len <= 3; len++) begin
            if ((p & ((1 << len) - 1)) == (p >> (4 - len)))
                res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/non_ssc_detector_if.sv
// Serial input and LED output bundle of non_ssc_detector.
// master = board side (drives data_in); slave = detector.
interface non_ssc_detector_if;
    logic       data_in;
    logic [4:0] out_light;

    modport master (output data_in, input out_light);
    modport slave  (input data_in, output out_light);
endinterface

// File: rtl/non_ssc_tick_gen.sv
// Sample-rate clock enable: tick is high for one clock in every SAMPLE_DIV
// clocks. The first tick after reset release comes on the SAMPLE_DIV-th clock.
module non_ssc_tick_gen #(
    parameter int SAMPLE_DIV = 500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int            CW   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Free-running counter: runs 0..SAMPLE_DIV-1, then wraps to 0.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_reg <= '0;
        else if (cnt_reg == LAST)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/non_ssc_detector.sv
// Slow serial pattern detector that drives 5 LEDs.
// data_in is sampled once per SAMPLE_DIV clocks.
// A 4-bit PATTERN is detected with a prefix-tracking FSM.
// out_light = {detect, last four samples}; it is registered one clock after
// the sampling edge.
// Optional macro NON_SSC_OVERLAP_EN: after a detection the FSM resumes from
// the pattern's self-overlap instead of S0.
module non_ssc_detector
    import non_ssc_pkg::*;
#(
    parameter int         SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter logic [3:0] PATTERN    = DEF_PATTERN
) (
    input  logic                clk,
    input  logic                rst,
    non_ssc_detector_if.slave   bus
);
`ifdef NON_SSC_OVERLAP_EN
    localparam state_t RESTART = state_t'(2'(border_len(PATTERN)));
`else
    localparam state_t RESTART = S0;
`endif

    logic       tick;
    state_t     state_reg, state_next;
    logic [3:0] hist_reg, hist_next;
    logic       det_reg, det_next;
    logic [4:0] out_reg;
    logic [2:0] adv;
    logic [2:0] adv_tab [8];

    non_ssc_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Transition table indexed by {state, sampled bit}.
    // Each entry is the new match length; 4 means a full detection.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_adv
            localparam int LEN = match_len(gi / 2, gi % 2, PATTERN);
            assign adv_tab[gi] = 3'(LEN);
        end
    endgenerate

    // Next-state logic: state and history move only on ticks.
    always_comb begin
        state_next = state_reg;
        hist_next  = hist_reg;
        det_next   = det_reg;
        adv        = adv_tab[{state_reg, bus.data_in}];
        if (tick) begin
            hist_next = {hist_reg[2:0], bus.data_in};
            if (adv == 3'd4) begin
                state_next = RESTART;
                det_next   = 1'b1;
            end else begin
                state_next = state_t'(adv[1:0]);
                det_next   = 1'b0;
            end
        end
    end

    // Registers for the FSM state, the sample history and the detect flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S0;
            hist_reg  <= '0;
            det_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            hist_reg  <= hist_next;
            det_reg   <= det_next;
        end
    end

    // LED register: the detect flag and the history always update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= '0;
        end else begin
            out_reg[DETECT_BIT]    <= det_reg;
            out_reg[HIST_LSB +: 4] <= hist_reg;
        end
    end

    assign bus.out_light = out_reg;
endmodule

// File: tb/tb_non_ssc_detector.sv
// Bench for non_ssc_detector (SAMPLE_DIV = 4, PATTERN = 1011).
// Reference model: keeps the list of sampled bits since reset.
// A detection is the last four samples equal to the pattern and, unless
// overlap is enabled, not sharing bits with the previous detection.
// The LED output is compared against the model on every clock.
// Directed sequences pin the model with literal expectations.
module tb_non_ssc_detector;
    localparam int         SD  = 4;
    localparam logic [3:0] PAT = 4'b1011;
`ifdef NON_SSC_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    non_ssc_detector_if bus ();

    always #5 clk = ~clk;

    non_ssc_detector #(.SAMPLE_DIV(SD), .PATTERN(PAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural model ----------------
    bit         samples[$];
    int         m_cnt       = 0;
    int         m_n         = 0;
    int         last_end    = 0;
    int         m_det_count = 0;
    logic [3:0] m_hist      = '0;
    logic       m_det       = 1'b0;
    logic [4:0] exp_out     = '0;

    // Model update at every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0;
                samples.delete();
                last_end = 0;
                m_det_count = 0;
                m_hist = '0;
                m_det = 1'b0;
                exp_out = '0;
            end else begin
                exp_out = {m_det, m_hist};
                m_cnt++;
                if (m_cnt == SD) begin
                    m_cnt = 0;
                    samples.push_back(bus.data_in);
                    m_n = samples.size();
                    for (int i = 0; i < 4; i++)
                        m_hist[i] = (m_n > i) ? samples[m_n - 1 - i] : 1'b0;
                    m_det = (m_n >= 4) && (m_hist == PAT) && (OVL || (m_n - 4) >= last_end);
                    if (m_det) begin
                        last_end = m_n;
                        m_det_count++;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int         vectors        = 0;
    int         errors         = 0;
    int         dut_det_cycles = 0;
    bit         pend           = 1'b0;
    logic [4:0] pend_exp       = '0;
    string      pend_name      = "";

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: compare against the model on the falling edge.
    task automatic step();
        @(negedge clk);
        if (rst)
            dut_det_cycles = 0;
        else if (bus.out_light[4] === 1'b1)
            dut_det_cycles++;
        check("cycle", bus.out_light, exp_out);
    endtask

    // Expectation for the LED value one clock after the most recent tick.
    task automatic expect_next(input logic [4:0] exp, input string name);
        pend      = 1'b1;
        pend_exp  = exp;
        pend_name = name;
    endtask

    task automatic take_pending();
        if (pend) begin
            check(pend_name, bus.out_light, pend_exp);
            pend = 1'b0;
        end
    endtask

    // Hold one bit for a full sample period.
    // Starts and ends on the falling edge right after a tick edge.
    task automatic send(input logic b);
        bus.data_in = b;
        step();
        take_pending();
        repeat (SD - 1) step();
    endtask

    // Pulse data_in high for two clocks mid-period; it is low at the tick.
    task automatic send_glitch();
        bus.data_in = 1'b0;
        step();
        take_pending();
        bus.data_in = 1'b1;
        step();
        step();
        bus.data_in = 1'b0;
        step();
    endtask

    task automatic flush();
        step();
        take_pending();
    endtask

    task automatic do_reset();
        if (pend) flush();
        rst = 1'b1;
        repeat (3) step();
        check("reset_out", bus.out_light, 5'b00000);
        rst = 1'b0;
    endtask

    logic [19:0] long_seq = 20'b1011_0010_1100_1011_0111;
    logic [6:0]  seven_seq = 7'b1011011;

    initial begin
        bus.data_in = 1'b0;
        do_reset();

        // Basic detection, then one more sample.
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        expect_next(5'b11011, "basic_detect");
        send(1'b0);
        expect_next(5'b00110, "basic_after");
        flush();

        // Seven samples: shows the overlap difference.
        do_reset();
        for (int i = 6; i >= 0; i--) send(seven_seq[i]);
        expect_next(OVL ? 5'b11011 : 5'b01011, "seven_last");
        flush();
        repeat (SD) step();
        check_int("seven_model_count", m_det_count, OVL ? 2 : 1);
        check_int("seven_dut_high_cycles", dut_det_cycles, SD * (OVL ? 2 : 1));

        // Long stream of 20 samples.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send(long_seq[19 - i]);
            if (i == 3)  expect_next(5'b11011, "long_s4");
            if (i == 15) expect_next(5'b11011, "long_s16");
        end
        flush();
        repeat (SD) step();
        check_int("long_model_count", m_det_count, OVL ? 4 : 3);
        check_int("long_dut_high_cycles", dut_det_cycles, SD * (OVL ? 4 : 3));

        // A mid-period pulse on data_in is not sampled.
        do_reset();
        send(1'b1); send(1'b1); send(1'b1);
        send_glitch();
        expect_next(5'b01110, "glitch_zero");
        flush();

        // Reset in the middle of a match, then check first-tick timing.
        do_reset();
        send(1'b1); send(1'b0); send(1'b1);
        do_reset();
        send(1'b1);
        check("first_tick_not_yet_visible", bus.out_light, 5'b00000);
        expect_next(5'b00001, "rst_mid_single");
        send(1'b0); send(1'b1); send(1'b1);
        expect_next(5'b11011, "rst_mid_then_detect");
        flush();

        // Random samples, each held for one full period.
        do_reset();
        repeat (60) send(1'($urandom_range(0, 1)));
        flush();

        // Random data every clock with occasional resets at any phase.
        repeat (800) begin
            bus.data_in = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) < 2);
            step();
        end
        rst = 1'b0;
        repeat (2 * SD) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/non_ssc_detector.md
Name: non_ssc_detector

Overview:
- Slow serial-bit pattern detector that drives 5 indicator LEDs on the board I/O layer.
- Samples the 1-bit `data_in` once every `SAMPLE_DIV` clocks through an internal clock-enable tick.
- Detects a 4-bit pattern in the sampled stream. Matches are non-overlapping by default.
- Shows the last four sampled bits plus a detect flag on `out_light`.

Parameters:
- SAMPLE_DIV, 500: clocks per sample period. Legal range is 2..65535.
- PATTERN, 4'b1011: target sequence. PATTERN[3] is the first bit received, PATTERN[0] the last.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, 1: serial data. Held stable for at least one sample period by the source.
- out_light, output, 5: [4] detect flag; [3:0] last four sampled bits, [0] newest.

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`).
- Reset state: tick counter = 0, FSM in S0, history = 4'b0000, out_light = 5'b00000.
- Tick generator:
  - Counter runs 0..SAMPLE_DIV-1 and wraps to 0.
  - `tick` is high for exactly one clock, when counter == SAMPLE_DIV-1.
  - The first tick after reset release comes on the SAMPLE_DIV-th clock.
- Sampling:
  - On a tick clock, `data_in` is captured: history <= {history[2:0], data_in}.
  - Nothing else changes on non-tick clocks.
- FSM states S0..S3 = number of pattern bits currently matched (0..3). It advances only on ticks.
  - In Sk, if the sampled bit == PATTERN[3-k], go to S(k+1). S3 plus a match is a detection.
  - On mismatch, go to the state equal to the longest proper prefix of PATTERN that is a suffix of (matched prefix + new bit). For 1011: S1 + 1 -> S1; S2 + 0 -> S0; S3 + 0 -> S2; S0 + 0 -> S0.
- Detection (non-overlapping):
  - FSM returns to S0; matched bits are not reused.
  - out_light[4] is set on the detecting tick and held until the next tick, where it is recomputed. It is high for exactly SAMPLE_DIV clocks per detection.
  - Back-to-back detections (possible only with overlap) keep it high continuously.
- Latency:
  - out_light is registered and updates on the clock after the tick-qualified edge. Both fields change together.
  - No combinational path from `data_in` to `out_light`.
- `data_in` changes between ticks are ignored; only the value at the tick edge matters.
- `data_in` is assumed already synchronous. No synchronizer is included.
- `rst` mid-period restarts the counter: the next tick comes SAMPLE_DIV clocks after release. History, FSM and out_light clear in the same cycle.
- `rst` has priority over a coincident tick.

Optional Feature:
- Macro: NON_SSC_OVERLAP_EN.
- Defined: overlapping detection. After a detection the FSM goes to the longest proper prefix of PATTERN that is also a suffix of PATTERN; for 1011 that is S1.
- Undefined (default): after a detection the FSM goes to S0.
- Tick, history and LED behaviour are identical in both builds.

Decomposition:
- Package non_ssc_pkg:
  - state typedef (S0..S3, 2-bit encoding);
  - default SAMPLE_DIV and PATTERN constants;
  - LED bit-index constants (DETECT_BIT = 4, HIST_LSB = 0).
- Sub-module non_ssc_tick_gen:
  - parameter SAMPLE_DIV; ports clk, rst, tick.
  - Holds the counter and wrap logic.
- The top holds the FSM, the history register and the output register.

Test Plan:
- Reset: assert rst for 3 clocks at any point -> out_light = 00000. First tick exactly SAMPLE_DIV clocks after release; check with SAMPLE_DIV = 4.
- Basic detect (SAMPLE_DIV = 4): samples 1,0,1,1 -> after the 4th tick out_light = 1_1011. Next tick with 0 -> out_light = 0_0110.
- Non-overlap vs overlap: samples 1,0,1,1,0,1,1 -> default build gives 1 detection (at the 4th sample). With NON_SSC_OVERLAP_EN, 2 detections (4th and 7th samples).
- Long stream 1,0,1,1,0,0,1,0,1,1,0,0,1,0,1,1,0,1,1,1 (default build):
  - detections at samples 4, 10 and 16 only;
  - the 20-sample detect count is 3;
  - with overlap enabled, detections at samples 4, 10, 16 and 19 (count 4).
- Mid-period toggle: `data_in` pulses 1 for 2 clocks between ticks and is 0 at the tick -> sampled bit is 0, history shifts in 0.
- Reset mid-match: samples 1,0,1, then rst, then a single 1 -> no detection. FSM in S1, out_light = 0_0001.
